mask_row_sequencer: RTL and testbench
=====================================

Name: mask_row_sequencer

Overview:
Upstream feeder for the row-gated mask path.
- Pulls 16-bit mask words from a first-word-fall-through (FWFT) mask FIFO.
- Sequences them row by row: presents `rowadd` and a registered `mstream` word stream to the downstream row-gating stage.
- Inserts a programmable settling gap between rows.
- Reports frame completion and FIFO underflow.

Parameters:
- NUM_ROWS, 320, rows per frame; rowadd runs 0..NUM_ROWS-1; must be ≤ 512.
- WORDS_PER_ROW, 20, mask words streamed per row; must be ≥ 1.
- ROW_GAP, 4, idle cycles after each row's last word before rowadd advances; 0 allowed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a frame when idle.
- abort  in  1  single-cycle pulse; terminates the frame.
- clr_err  in  1  clears the sticky underflow flag.
- fifo_dout  in  16  FWFT FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pops the FIFO head.
- rowadd  out  9  current row address.
- mstream  out  16  registered mask word.
- mstream_valid  out  1  mstream holds a new word this cycle.
- row_load  out  1  pulse coincident with the row's last mstream_valid.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  single-cycle pulse at frame end.
- underflow  out  1  sticky flag: FIFO was empty while a word was required.

Behaviour:
Reset (async assert on rst_n low):
- State IDLE.
- rowadd=0, mstream=16'h0000.
- mstream_valid=0, row_load=0, busy=0, done=0, underflow=0.
- Word counter=0, gap counter=0.

State machine: IDLE, STREAM, GAP, DONE.
- **IDLE**
  - start=1 → STREAM next cycle; rowadd=0, word counter=0, underflow cleared.
  - start while not IDLE is ignored.
- **STREAM**
  - fifo_rd_en = (state==STREAM) && !fifo_empty. This is combinational, so there are no pops beyond WORDS_PER_ROW per row.
  - Each pop: mstream<=fifo_dout and mstream_valid<=1 the following cycle, i.e. 1-cycle latency from pop to mstream.
  - Word counter increments per pop.
  - On the pop of word WORDS_PER_ROW-1:
    - row_load<=1 alongside that word's mstream_valid.
    - Word counter resets.
    - Next state is GAP if ROW_GAP>0.
    - Otherwise the next state is the row advance, as below.
  - fifo_empty=1 in STREAM: stall, no pop, mstream_valid=0 next cycle, underflow<=1. mstream holds its last value.
- **GAP**
  - Counts ROW_GAP cycles; mstream_valid=0.
  - At the end, if rowadd==NUM_ROWS-1 → DONE.
  - Otherwise rowadd<=rowadd+1 → STREAM.
  - With ROW_GAP=0 the same decision is taken directly at the last pop.
- **DONE**
  - done=1 for exactly one cycle, busy<=0, rowadd<=0.
  - Next state IDLE.

Timing and control rules:
- rowadd is stable during a row and its gap; it changes only at the row-advance edge. It never exceeds NUM_ROWS-1 and never wraps mid-frame.
- busy=1 in STREAM and GAP.
- abort in any non-IDLE state → IDLE next cycle.
  - rowadd=0, counters=0, mstream_valid=0, row_load=0, busy=0.
  - No done pulse; underflow is retained.
  - Words already in the FIFO are not flushed.
- abort and start in the same cycle while IDLE: abort wins, stay IDLE.
- clr_err clears underflow.
  - If an underflow event occurs in the same cycle, set wins.
  - clr_err does not affect the state machine.
- Counters are sized $clog2 of their parameter, with a minimum of 1 bit.

Test Plan:
- NUM_ROWS=3, WORDS_PER_ROW=4, ROW_GAP=2; FIFO preloaded with 12 words 16'h0001..16'h000C; start pulse.
  → mstream sequence 1..C.
  → rowadd 0,0,0,0 | 1×4 | 2×4.
  → row_load on words 4, 8 and C.
  → 2 idle cycles between rows.
  → single done pulse; busy falls with done; underflow=0.
- Same setup with ROW_GAP=0.
  → mstream_valid continuous for 12 cycles.
  → rowadd increments on the cycle after each row_load.
- FIFO empty for 3 cycles after word 6.
  → fifo_rd_en=0 and mstream_valid=0 for 3 cycles; underflow=1.
  → stream resumes with word 7 on rowadd 1.
  → clr_err afterwards → underflow=0.
- abort asserted while in GAP after row 1.
  → next cycle IDLE, busy=0, rowadd=0, no done.
  → a subsequent start restarts at row 0 with underflow cleared.
- start pulsed again mid-frame.
  → ignored; the frame completes with exactly one done.
- Assert rst_n low mid-STREAM, asynchronously between clock edges.
  → all outputs reach reset values immediately.
  → fifo_rd_en=0 while in reset.

Source files
------------

// File: rtl/mask_row_sequencer.sv
// mask_row_sequencer
// Pulls 16-bit mask words from a FWFT FIFO and streams them row by row to the
// row-gating stage. Each registered mstream word is tagged with its row
// address. A programmable settling gap follows each row. The block also reports
// frame completion and FIFO underflow.
module mask_row_sequencer #(
    parameter int NUM_ROWS      = 320,  // rows per frame, at most 512
    parameter int WORDS_PER_ROW = 20,   // at least 1
    parameter int ROW_GAP       = 4     // idle cycles after each row, 0 allowed
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        clr_err,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [8:0]  rowadd,
    output logic [15:0] mstream,
    output logic        mstream_valid,
    output logic        row_load,
    output logic        busy,
    output logic        done,
    output logic        underflow
);

    localparam int WCW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int GCW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_ROW - 1);
    localparam logic [GCW-1:0] LAST_GAP  = GCW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
    localparam logic [8:0]     LAST_ROW  = 9'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state, state_d;
    logic [WCW-1:0] word_cnt;
    logic [GCW-1:0] gap_cnt;
    logic [8:0]     row_cnt;    // row being fetched; drives the row decisions

    logic pop, last_pop, gap_end, last_row, row_step;
    logic start_ok, abort_ok;

    // Decode the per-cycle events that drive the state machine and counters.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first,
        // otherwise a path that skips it infers a latch.
        row_step = 1'b0;
        pop      = (state == S_STREAM) && !fifo_empty;
        last_pop = pop && (word_cnt == LAST_WORD);
        gap_end  = (state == S_GAP) && (gap_cnt == LAST_GAP);
        last_row = (row_cnt == LAST_ROW);
        start_ok = (state == S_IDLE) && start && !abort;
        abort_ok = (state != S_IDLE) && abort;
        if (ROW_GAP == 0) begin
            row_step = last_pop;
        end else begin
            row_step = gap_end;
        end
    end

    assign fifo_rd_en = pop;

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (start_ok) state_d = S_STREAM;
            S_STREAM: begin
                if (last_pop) begin
                    if (ROW_GAP > 0)   state_d = S_GAP;
                    else if (last_row) state_d = S_DONE;
                    else               state_d = S_STREAM;
                end
            end
            S_GAP:    if (gap_end) state_d = last_row ? S_DONE : S_STREAM;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_ok) state_d = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge values, independent of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Word, gap and row counters; cleared on frame start, frame end and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            gap_cnt  <= '0;
            row_cnt  <= '0;
        end else if (abort_ok || start_ok || state == S_DONE) begin
            word_cnt <= '0;
            gap_cnt  <= '0;
            row_cnt  <= '0;
        end else begin
            if (pop) word_cnt <= last_pop ? '0 : word_cnt + WCW'(1);
            gap_cnt <= (state == S_GAP && !gap_end) ? gap_cnt + GCW'(1) : '0;
            if (row_step && !last_row) row_cnt <= row_cnt + 9'd1;
        end
    end

    // Registered word stream: one cycle from pop to mstream/mstream_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstream       <= 16'h0000;
            mstream_valid <= 1'b0;
            row_load      <= 1'b0;
        end else begin
            mstream_valid <= pop && !abort_ok;
            row_load      <= last_pop && !abort_ok;
            if (pop) mstream <= fifo_dout;
        end
    end

    // Status flags track the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == S_STREAM) || (state_d == S_GAP);
            done <= (state_d == S_DONE);
        end
    end

    // Sticky underflow: a stall sets it and wins over clr_err or a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 underflow <= 1'b0;
        else if (state == S_STREAM && fifo_empty)   underflow <= 1'b1;
        else if (clr_err || start_ok)               underflow <= 1'b0;
    end

    // With no gap the fetch side moves to the next row at the last pop. The
    // published row address trails it by one cycle. This keeps rowadd aligned
    // with the mstream words of the row it labels.
    if (ROW_GAP == 0) begin : g_rowadd_lag
        logic [8:0] rowadd_q;

        // Follow row_cnt one cycle late; forced to zero at frame end and abort.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                             rowadd_q <= 9'd0;
            else if (abort_ok || state == S_DONE)   rowadd_q <= 9'd0;
            else                                    rowadd_q <= row_cnt;
        end

        assign rowadd = rowadd_q;
    end else begin : g_rowadd_direct
        assign rowadd = row_cnt;
    end

endmodule

// File: tb/tb_mask_row_sequencer.sv
// Directed bench for mask_row_sequencer. Instance A uses a 2-cycle row gap and
// instance B uses no gap. Each instance is fed by a small FWFT FIFO model. An
// expected-word queue is filled as words are loaded and drained by per-instance
// monitors on the falling edge.
module tb_mask_row_sequencer;

    localparam int NR  = 3;
    localparam int WPR = 4;

    typedef struct {
        logic [15:0] data;
        logic [8:0]  row;
        logic        last;
        int          delta;   // expected cycles since previous word, 0 = unchecked
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 0, abort_a = 0, clr_err_a = 0;
    logic [15:0] fifo_dout_a, mstream_a;
    logic        fifo_empty_a, fifo_rd_en_a, mstream_valid_a, row_load_a;
    logic        busy_a, done_a, underflow_a;
    logic [8:0]  rowadd_a;

    logic        start_b = 0, abort_b = 0, clr_err_b = 0;
    logic [15:0] fifo_dout_b, mstream_b;
    logic        fifo_empty_b, fifo_rd_en_b, mstream_valid_b, row_load_b;
    logic        busy_b, done_b, underflow_b;
    logic [8:0]  rowadd_b;

    mask_row_sequencer #(.NUM_ROWS(NR), .WORDS_PER_ROW(WPR), .ROW_GAP(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .clr_err(clr_err_a),
        .fifo_dout(fifo_dout_a), .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a),
        .rowadd(rowadd_a), .mstream(mstream_a), .mstream_valid(mstream_valid_a),
        .row_load(row_load_a), .busy(busy_a), .done(done_a), .underflow(underflow_a)
    );

    mask_row_sequencer #(.NUM_ROWS(NR), .WORDS_PER_ROW(WPR), .ROW_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .clr_err(clr_err_b),
        .fifo_dout(fifo_dout_b), .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b),
        .rowadd(rowadd_b), .mstream(mstream_b), .mstream_valid(mstream_valid_b),
        .row_load(row_load_b), .busy(busy_b), .done(done_b), .underflow(underflow_b)
    );

    // FWFT FIFO models
    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    assign fifo_empty_a = (rd_a == wr_a);
    assign fifo_dout_a  = mem_a[rd_a[5:0]];
    assign fifo_empty_b = (rd_b == wr_b);
    assign fifo_dout_b  = mem_b[rd_b[5:0]];

    always @(posedge clk) begin
        if (fifo_rd_en_a) rd_a <= rd_a + 1;
        if (fifo_rd_en_b) rd_b <= rd_b + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load words into a FIFO and queue their expected row/last/spacing.
    task automatic load(input bit which, input int first_val, input int count,
                        input int start_idx, input int gap, input int d0);
        for (int j = 0; j < count; j++) begin
            int   k;
            int   d;
            exp_t e;
            k = start_idx + j;
            d = (k % WPR == 0) ? ((k == 0) ? 0 : gap + 1) : 1;
            if (j == 0 && d0 >= 0) d = d0;
            e.data  = 16'(first_val + j);
            e.row   = 9'(k / WPR);
            e.last  = (k % WPR == WPR - 1);
            e.delta = d;
            if (which) begin
                mem_b[wr_b[5:0]] = e.data;
                wr_b = wr_b + 1;
                sb_b.push_back(e);
            end else begin
                mem_a[wr_a[5:0]] = e.data;
                wr_a = wr_a + 1;
                sb_a.push_back(e);
            end
        end
    endtask

    // Monitor A
    exp_t ea;
    int   prev_a = 0;
    int   done_cnt_a = 0;
    always @(negedge clk) begin
        if (mstream_valid_a) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_word", 32'(sb_a.size()), 1);
            end else begin
                ea = sb_a.pop_front();
                check("a_mstream", 32'(mstream_a), 32'(ea.data));
                check("a_rowadd", 32'(rowadd_a), 32'(ea.row));
                check("a_row_load", 32'(row_load_a), 32'(ea.last));
                if (ea.delta > 0) check("a_spacing", 32'(cyc - prev_a), 32'(ea.delta));
            end
            prev_a = cyc;
        end else begin
            check("a_row_load_idle", 32'(row_load_a), 0);
        end
        if (done_a) begin
            done_cnt_a++;
            check("a_busy_at_done", 32'(busy_a), 0);
        end
    end

    // Monitor B
    exp_t       eb;
    int         prev_b = 0;
    int         done_cnt_b = 0;
    logic       rl_pend_b = 0;
    logic [8:0] rl_row_b = 0;
    always @(negedge clk) begin
        if (rl_pend_b) check("b_rowadd_after_row_load", 32'(rowadd_b), 32'(rl_row_b + 9'd1));
        rl_pend_b = 0;
        if (mstream_valid_b) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_word", 32'(sb_b.size()), 1);
            end else begin
                eb = sb_b.pop_front();
                check("b_mstream", 32'(mstream_b), 32'(eb.data));
                check("b_rowadd", 32'(rowadd_b), 32'(eb.row));
                check("b_row_load", 32'(row_load_b), 32'(eb.last));
                if (eb.delta > 0) check("b_spacing", 32'(cyc - prev_b), 32'(eb.delta));
                rl_pend_b = eb.last && (eb.row != 9'(NR - 1));
                rl_row_b  = eb.row;
            end
            prev_b = cyc;
        end else begin
            check("b_row_load_idle", 32'(row_load_b), 0);
        end
        if (done_b) begin
            done_cnt_b++;
            check("b_busy_at_done", 32'(busy_b), 0);
        end
    end

    task automatic check_reset_a(input string pfx);
        check({pfx, "_rowadd"}, 32'(rowadd_a), 0);
        check({pfx, "_mstream"}, 32'(mstream_a), 0);
        check({pfx, "_mstream_valid"}, 32'(mstream_valid_a), 0);
        check({pfx, "_row_load"}, 32'(row_load_a), 0);
        check({pfx, "_busy"}, 32'(busy_a), 0);
        check({pfx, "_done"}, 32'(done_a), 0);
        check({pfx, "_underflow"}, 32'(underflow_a), 0);
        check({pfx, "_fifo_rd_en"}, 32'(fifo_rd_en_a), 0);
    endtask

    task automatic wait_done_a(input int target);
        int n = 0;
        while (done_cnt_a < target && n < 300) begin
            step();
            n++;
        end
        check("a_done_count", 32'(done_cnt_a), 32'(target));
    endtask

    task automatic wait_done_b(input int target);
        int n = 0;
        while (done_cnt_b < target && n < 300) begin
            step();
            n++;
        end
        check("b_done_count", 32'(done_cnt_b), 32'(target));
    endtask

    initial begin
        int n;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("rst_a");
        check("rst_b_busy", 32'(busy_b), 0);
        check("rst_b_underflow", 32'(underflow_b), 0);
        rst_n = 1'b1;
        step();

        // Full frame on both instances: gap 2 on A, no gap on B
        load(0, 1, NR * WPR, 0, 2, -1);
        load(1, 1, NR * WPR, 0, 0, -1);
        start_a = 1; start_b = 1;
        step();
        start_a = 0; start_b = 0;
        check("a_busy_after_start", 32'(busy_a), 1);
        check("b_busy_after_start", 32'(busy_b), 1);
        wait_done_b(1);
        wait_done_a(1);
        step();
        check("a_frame1_underflow", 32'(underflow_a), 0);
        check("b_frame1_underflow", 32'(underflow_b), 0);
        check("a_frame1_rowadd_idle", 32'(rowadd_a), 0);
        check("b_frame1_rowadd_idle", 32'(rowadd_b), 0);
        check("a_frame1_sb_left", 32'(sb_a.size()), 0);
        check("b_frame1_sb_left", 32'(sb_b.size()), 0);

        // FIFO runs dry for 3 cycles after word 6
        load(0, 1, 6, 0, 2, -1);
        start_a = 1;
        step();
        start_a = 0;
        n = 0;
        while (rd_a != wr_a && n < 100) begin
            step();
            n++;
        end
        check("a_stall_reached", 32'(rd_a), 32'(wr_a));
        check("a_stall_rd_en_c1", 32'(fifo_rd_en_a), 0);
        step();
        check("a_stall_rd_en_c2", 32'(fifo_rd_en_a), 0);
        check("a_stall_valid_c2", 32'(mstream_valid_a), 0);
        check("a_stall_hold_c2", 32'(mstream_a), 32'h6);
        check("a_stall_underflow", 32'(underflow_a), 1);
        step();
        check("a_stall_rd_en_c3", 32'(fifo_rd_en_a), 0);
        check("a_stall_valid_c3", 32'(mstream_valid_a), 0);
        step();
        check("a_stall_valid_c4", 32'(mstream_valid_a), 0);
        load(0, 7, 6, 6, 2, 4);
        wait_done_a(2);
        step();
        check("a_underflow_sticky", 32'(underflow_a), 1);
        clr_err_a = 1;
        step();
        clr_err_a = 0;
        check("a_underflow_cleared", 32'(underflow_a), 0);

        // Abort in the gap after row 1, with underflow set beforehand
        start_a = 1;
        step();
        start_a = 0;
        step();
        step();
        check("a_empty_start_underflow", 32'(underflow_a), 1);
        load(0, 16'h21, 2 * WPR, 0, 2, -1);
        n = 0;
        while (!(row_load_a && rowadd_a == 9'd1) && n < 100) begin
            step();
            n++;
        end
        check("a_reached_row1_end", 32'(row_load_a), 1);
        abort_a = 1;
        step();
        abort_a = 0;
        check("a_abort_busy", 32'(busy_a), 0);
        check("a_abort_rowadd", 32'(rowadd_a), 0);
        check("a_abort_valid", 32'(mstream_valid_a), 0);
        check("a_abort_done", 32'(done_a), 0);
        check("a_abort_underflow_kept", 32'(underflow_a), 1);
        repeat (4) step();
        check("a_abort_no_done", 32'(done_cnt_a), 2);
        check("a_abort_sb_left", 32'(sb_a.size()), 0);

        // start together with abort while idle: abort wins
        start_a = 1; abort_a = 1;
        step();
        start_a = 0; abort_a = 0;
        check("a_start_abort_busy", 32'(busy_a), 0);
        check("a_start_abort_underflow", 32'(underflow_a), 1);

        // Restart clears underflow; a second start mid-frame is ignored
        load(0, 16'h31, NR * WPR, 0, 2, -1);
        start_a = 1;
        step();
        start_a = 0;
        check("a_restart_busy", 32'(busy_a), 1);
        check("a_restart_underflow", 32'(underflow_a), 0);
        check("a_restart_rowadd", 32'(rowadd_a), 0);
        repeat (6) step();
        start_a = 1;
        step();
        start_a = 0;
        wait_done_a(3);
        repeat (4) step();
        check("a_single_done", 32'(done_cnt_a), 3);
        check("a_restart_sb_left", 32'(sb_a.size()), 0);

        // Asynchronous reset in the middle of row 1
        load(0, 16'h41, 2 * WPR, 0, 2, -1);
        start_a = 1;
        step();
        start_a = 0;
        n = 0;
        while (!(mstream_valid_a && rowadd_a == 9'd1) && n < 100) begin
            step();
            n++;
        end
        check("a_reached_row1_stream", 32'(rowadd_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("async_rst_a");
        @(posedge clk);
        #1;
        check("async_rst_rd_en_held", 32'(fifo_rd_en_a), 0);
        sb_a.delete();
        wr_a = rd_a;
        rst_n = 1'b1;
        repeat (3) step();
        check("a_post_rst_busy", 32'(busy_a), 0);
        check("a_post_rst_done_cnt", 32'(done_cnt_a), 3);
        check("b_final_done_cnt", 32'(done_cnt_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
